// File: rtl/arrow_pkg.sv
// Shared types and default geometry for the arrow sequencer and its slot registers.
package arrow_pkg;

  // Arrow direction doubles as the sprite rotate code.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } arrow_dir_t;

  // Sequencer top-level states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_SPEED     = 2;
  localparam int DEF_HIT_Y     = 400;
  localparam int DEF_WINDOW    = 16;
  localparam int DEF_X_BASE    = 200;
  localparam int DEF_X_STEP    = 40;

  localparam int Y_MAX = 1023;

  // Move a y coordinate down by step pixels, sticking at the bottom of the 10-bit range.
  function automatic logic [9:0] y_advance(input logic [9:0] y, input int step);
    int sum;
    sum = int'(y) + step;
    if (sum > Y_MAX) begin
      return 10'(Y_MAX);
    end
    return 10'(sum);
  endfunction

  // Horizontal lane position for a given direction.
  function automatic logic [10:0] lane_x(input arrow_dir_t dir, input int base, input int step);
    return 11'(base + int'(dir) * step);
  endfunction

endpackage

// File: rtl/arrow_slot.sv
// One live-arrow register set: active flag, position and rotate code.
// Clear wins over load, load wins over move; an idle slot reads as all zeros.
module arrow_slot
  import arrow_pkg::*;
#(
  parameter int SPEED = DEF_SPEED
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        load_in,
  input  logic [10:0] load_x_in,
  input  logic [1:0]  load_rot_in,
  input  logic        move_in,
  input  logic        clear_in,
  output logic        active_out,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [1:0]  rot_out
);

  // Slot state: cleared on retirement/drain, seeded at the top on spawn, slid down on ticks.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_out <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      rot_out    <= '0;
    end else if (clear_in) begin
      active_out <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      rot_out    <= '0;
    end else if (load_in) begin
      active_out <= 1'b1;
      x_out      <= load_x_in;
      y_out      <= '0;
      rot_out    <= load_rot_in;
    end else if (move_in && active_out) begin
      y_out <= y_advance(y_out, SPEED);
    end
  end

endmodule

// File: rtl/arrow_sequencer.sv
// Rhythm-game arrow sequencer: spawns falling arrows into a ring of slots,
// judges button presses against the oldest arrow and keeps score and combo.
module arrow_sequencer
  import arrow_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SPEED     = DEF_SPEED,
  parameter int HIT_Y     = DEF_HIT_Y,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int X_BASE    = DEF_X_BASE,
  parameter int X_STEP    = DEF_X_STEP
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   frame_tick_in,
  input  logic                   spawn_valid_in,
  input  logic [1:0]             spawn_dir_in,
  output logic                   spawn_ready_out,
  input  logic                   btn_valid_in,
  input  logic [1:0]             btn_dir_in,
  output logic [NUM_SLOTS*11-1:0] slot_x_out,
  output logic [NUM_SLOTS*10-1:0] slot_y_out,
  output logic [NUM_SLOTS*2-1:0]  slot_rot_out,
  output logic [NUM_SLOTS-1:0]    slot_active_out,
  output logic [NUM_SLOTS-1:0]    slot_next_out,
  output logic                   hit_out,
  output logic                   miss_out,
  output logic [7:0]             score_out,
  output logic [7:0]             combo_out
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SLOTS);
  localparam int EARLY_Y = HIT_Y - WINDOW;
  localparam int LATE_Y  = HIT_Y + WINDOW;

  seq_state_t state_q;
  seq_state_t state_d;

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_idx;
  logic [CNT_W-1:0] count_q;

  logic [10:0] x_arr   [NUM_SLOTS];
  logic [9:0]  y_arr   [NUM_SLOTS];
  logic [1:0]  rot_arr [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] clear_vec;

  arrow_dir_t  spawn_dir;
  logic [10:0] spawn_x;
  logic [9:0]  head_y;
  logic [9:0]  head_y_moved;
  logic [1:0]  head_rot;
  logic        has_head;
  logic        in_window;
  logic        late;

  logic spawn_fire;
  logic tick_move;
  logic btn_hit;
  logic btn_miss;
  logic timeout;
  logic drain_clear;
  logic retire;

  assign spawn_dir    = arrow_dir_t'(spawn_dir_in);
  assign spawn_x      = lane_x(spawn_dir, X_BASE, X_STEP);
  assign tail_idx     = head_q + count_q[IDX_W-1:0];
  assign has_head     = (count_q != '0);
  assign head_y       = y_arr[head_q];
  assign head_rot     = rot_arr[head_q];
  assign head_y_moved = frame_tick_in ? y_advance(head_y, SPEED) : head_y;
  assign in_window    = (int'(head_y) >= EARLY_Y) && (int'(head_y) <= LATE_Y);
  assign late         = (int'(head_y_moved) > LATE_Y);
  assign retire       = btn_hit || timeout;

  // Current game state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus per-cycle judgement; all inputs are only honoured while running.
  always_comb begin
    state_d         = state_q;
    spawn_ready_out = 1'b0;
    spawn_fire      = 1'b0;
    tick_move       = 1'b0;
    btn_hit         = 1'b0;
    btn_miss        = 1'b0;
    timeout         = 1'b0;
    drain_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable_in) begin
          state_d = DRAIN;
        end
        spawn_ready_out = (count_q < FULL);
        spawn_fire      = spawn_valid_in && spawn_ready_out;
        tick_move       = frame_tick_in;
        if (btn_valid_in) begin
          if (has_head && in_window && (btn_dir_in == head_rot)) begin
            btn_hit = 1'b1;
          end else begin
            btn_miss = 1'b1;
          end
        end else if (has_head && late) begin
          timeout = 1'b1;
        end
      end
      DRAIN: begin
        drain_clear = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ring-buffer bookkeeping, score/combo and the judgement pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q    <= '0;
      count_q   <= '0;
      score_out <= '0;
      combo_out <= '0;
      hit_out   <= 1'b0;
      miss_out  <= 1'b0;
    end else begin
      hit_out  <= btn_hit;
      miss_out <= btn_miss || timeout;
      if (drain_clear) begin
        head_q    <= '0;
        count_q   <= '0;
        combo_out <= '0;
      end else begin
        if (retire) begin
          head_q <= head_q + IDX_W'(1);
        end
        if (spawn_fire && !retire) begin
          count_q <= count_q + CNT_W'(1);
        end else if (!spawn_fire && retire) begin
          count_q <= count_q - CNT_W'(1);
        end
        if (btn_hit) begin
          if (score_out != 8'hFF) begin
            score_out <= score_out + 8'd1;
          end
          if (combo_out != 8'hFF) begin
            combo_out <= combo_out + 8'd1;
          end
        end else if (btn_miss || timeout) begin
          combo_out <= '0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign load_vec[i]  = spawn_fire && (tail_idx == IDX_W'(i));
    assign clear_vec[i] = drain_clear || (retire && (head_q == IDX_W'(i)));

    arrow_slot #(
      .SPEED(SPEED)
    ) u_slot (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .load_in     (load_vec[i]),
      .load_x_in   (spawn_x),
      .load_rot_in (spawn_dir_in),
      .move_in     (tick_move),
      .clear_in    (clear_vec[i]),
      .active_out  (slot_active_out[i]),
      .x_out       (x_arr[i]),
      .y_out       (y_arr[i]),
      .rot_out     (rot_arr[i])
    );

    assign slot_x_out[i*11 +: 11]  = x_arr[i];
    assign slot_y_out[i*10 +: 10]  = y_arr[i];
    assign slot_rot_out[i*2 +: 2]  = rot_arr[i];
    assign slot_next_out[i]        = has_head && (head_q == IDX_W'(i));
  end

endmodule

// File: tb/tb_arrow_sequencer.sv
// Directed bench for arrow_sequencer with default parameters.
module tb_arrow_sequencer;

  localparam int NS = 4;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            frame_tick;
  logic            spawn_valid;
  logic [1:0]      spawn_dir;
  logic            spawn_ready;
  logic            btn_valid;
  logic [1:0]      btn_dir;
  logic [NS*11-1:0] slot_x;
  logic [NS*10-1:0] slot_y;
  logic [NS*2-1:0]  slot_rot;
  logic [NS-1:0]    slot_active;
  logic [NS-1:0]    slot_next;
  logic            hit;
  logic            miss;
  logic [7:0]      score;
  logic [7:0]      combo;

  int tests_run  = 0;
  int fail_count = 0;

  typedef struct {
    logic       en;
    logic       tick;
    logic       sv;
    logic [1:0] sd;
    logic       bv;
    logic [1:0] bd;
    logic       ready;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [7:0] combo;
    logic [3:0] active;
    logic [3:0] next;
  } vec_t;

  vec_t vecs [8];

  arrow_sequencer dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .enable_in       (enable),
    .frame_tick_in   (frame_tick),
    .spawn_valid_in  (spawn_valid),
    .spawn_dir_in    (spawn_dir),
    .spawn_ready_out (spawn_ready),
    .btn_valid_in    (btn_valid),
    .btn_dir_in      (btn_dir),
    .slot_x_out      (slot_x),
    .slot_y_out      (slot_y),
    .slot_rot_out    (slot_rot),
    .slot_active_out (slot_active),
    .slot_next_out   (slot_next),
    .hit_out         (hit),
    .miss_out        (miss),
    .score_out       (score),
    .combo_out       (combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic en, input logic tick, input logic sv, input logic [1:0] sd,
                              input logic bv, input logic [1:0] bd, input logic ready, input logic h,
                              input logic m, input logic [7:0] sc, input logic [7:0] cb,
                              input logic [3:0] act, input logic [3:0] nxt);
    vec_t v;
    v.en = en; v.tick = tick; v.sv = sv; v.sd = sd; v.bv = bv; v.bd = bd;
    v.ready = ready; v.hit = h; v.miss = m; v.score = sc; v.combo = cb;
    v.active = act; v.next = nxt;
    return v;
  endfunction

  function automatic int get_x(input int i);
    return int'(slot_x[i*11 +: 11]);
  endfunction

  function automatic int get_y(input int i);
    return int'(slot_y[i*10 +: 10]);
  endfunction

  function automatic int get_rot(input int i);
    return int'(slot_rot[i*2 +: 2]);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave time at 1 ns past the edge.
  task automatic applyStimulus(input logic en, input logic tick, input logic sv, input logic [1:0] sd,
                               input logic bv, input logic [1:0] bd);
    enable      = en;
    frame_tick  = tick;
    spawn_valid = sv;
    spawn_dir   = sd;
    btn_valid   = bv;
    btn_dir     = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ready, input int h, input int m,
                           input int sc, input int cb, input int act, input int nxt);
    checkOutput({tag, ".ready"},  int'(spawn_ready), ready);
    checkOutput({tag, ".hit"},    int'(hit), h);
    checkOutput({tag, ".miss"},   int'(miss), m);
    checkOutput({tag, ".score"},  int'(score), sc);
    checkOutput({tag, ".combo"},  int'(combo), cb);
    checkOutput({tag, ".active"}, int'(slot_active), act);
    checkOutput({tag, ".next"},   int'(slot_next), nxt);
  endtask

  task automatic run_ticks(input int n, input string tag);
    int pulses = 0;
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
      if (hit || miss) pulses++;
    end
    checkOutput({tag, ".pulses"}, pulses, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    enable = 1'b0; frame_tick = 1'b0; spawn_valid = 1'b0; spawn_dir = 2'd0;
    btn_valid = 1'b0; btn_dir = 2'd0;
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state.
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset.x", int'(slot_x != '0), 0);
    checkOutput("reset.y", int'(slot_y != '0), 0);
    checkOutput("reset.rot", int'(slot_rot != '0), 0);
    rst_n = 1'b1;

    // Start, empty-button miss, fill to four, blocked spawn, early-button miss.
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0000, 4'b0000);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 4'b0000, 4'b0000);
    vecs[2] = mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0001, 4'b0001);
    vecs[3] = mk(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0011, 4'b0001);
    vecs[4] = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0111, 4'b0001);
    vecs[5] = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'b1111, 4'b0001);
    vecs[6] = mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'b1111, 4'b0001);
    vecs[7] = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 4'b1111, 4'b0001);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].en, vecs[i].tick, vecs[i].sv, vecs[i].sd, vecs[i].bv, vecs[i].bd);
      check_all($sformatf("row%0d", i), int'(vecs[i].ready), int'(vecs[i].hit), int'(vecs[i].miss),
                int'(vecs[i].score), int'(vecs[i].combo), int'(vecs[i].active), int'(vecs[i].next));
    end
    checkOutput("lane.x0", get_x(0), 280);
    checkOutput("lane.rot0", get_rot(0), 2);
    checkOutput("lane.x1", get_x(1), 320);
    checkOutput("lane.x2", get_x(2), 240);
    checkOutput("lane.x3", get_x(3), 200);

    // 200 ticks bring every arrow to the target line.
    run_ticks(200, "fall200");
    checkOutput("fall200.y0", get_y(0), 400);
    checkOutput("fall200.next", int'(slot_next), 4'b0001);

    // Hit on the head while a fifth spawn waits on a full ring.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2);
    check_all("hit1", 1, 1, 0, 1, 1, 4'b1110, 4'b0010);
    checkOutput("hit1.x0_cleared", get_x(0), 0);
    checkOutput("hit1.y0_cleared", get_y(0), 0);

    // The waiting spawn lands in the freed slot 0.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
    check_all("refill", 0, 0, 0, 1, 1, 4'b1111, 4'b0010);
    checkOutput("refill.x0", get_x(0), 240);
    checkOutput("refill.rot0", get_rot(0), 1);

    // Wrong direction at y=400: miss, arrow stays.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
    check_all("wrongdir", 0, 0, 1, 1, 0, 4'b1111, 4'b0010);

    // Move the head to the window edge, then hit together with a tick.
    run_ticks(8, "edge8");
    checkOutput("edge8.y1", get_y(1), 416);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
    check_all("hitTick", 1, 1, 0, 2, 1, 4'b1101, 4'b0100);
    checkOutput("hitTick.y2", get_y(2), 418);

    // Two late arrows retire one per cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    check_all("late1", 1, 0, 1, 2, 0, 4'b1001, 4'b1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    check_all("late2", 1, 0, 1, 2, 0, 4'b0001, 4'b0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkOutput("quiet.miss", int'(miss), 0);

    // Remaining arrow falls past the window on a tick.
    run_ticks(199, "fall199");
    checkOutput("fall199.y0", get_y(0), 416);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    check_all("timeout", 1, 0, 1, 2, 0, 4'b0000, 4'b0000);

    // Three live arrows, then an asynchronous reset.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    check_all("three", 1, 0, 0, 2, 0, 4'b1110, 4'b0010);
    checkOutput("three.y1", get_y(1), 2);
    enable = 1'b0; frame_tick = 1'b0; spawn_valid = 1'b0; btn_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_all("midreset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midreset.y1", get_y(1), 0);
    @(posedge clk);
    #1;
    checkOutput("midreset.pulse", int'(hit || miss), 0);
    rst_n = 1'b1;

    // Fresh game: one hit, two live arrows, then disable and drain.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkOutput("restart.ready", int'(spawn_ready), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("restart.x0", get_x(0), 200);
    run_ticks(200, "fall200b");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
    check_all("hit2", 1, 1, 0, 1, 1, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
    check_all("prefill", 1, 0, 0, 1, 1, 4'b0110, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    checkOutput("drain.ready", int'(spawn_ready), 0);
    checkOutput("drain.active", int'(slot_active), 4'b0110);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    check_all("idle", 0, 0, 0, 1, 0, 4'b0000, 4'b0000);

    // Inputs ignored while idle.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
    check_all("ignored", 0, 0, 0, 1, 0, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
